// File: rtl/slow_periph_async_bus_adapter.sv
// Avalon-MM slave that turns 32-bit accesses into one or two timed 16-bit beats on an async parallel bus.
// Optional macro SLOW_PERIPH_EXT_WAIT_EN adds a synchronized ext_wait_n input that stretches STROBE.
module slow_periph_async_bus_adapter #(
  parameter int ADDR_W = 22,
  parameter int SETUP  = 2,
  parameter int STROBE = 4,
  parameter int HOLD   = 1,
  parameter int TURN   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [25:0]       s_address,
  input  logic [3:0]        s_byteenable,
  input  logic              s_read,
  input  logic              s_write,
  input  logic [31:0]       s_writedata,
  output logic              s_waitrequest,
  output logic [31:0]       s_readdata,
  output logic              s_readdatavalid,
  output logic [ADDR_W-1:0] ext_addr,
  output logic              ext_cs_n,
  output logic              ext_oe_n,
  output logic              ext_we_n,
  output logic [1:0]        ext_be_n,
  output logic [15:0]       ext_dout,
  output logic              ext_dout_en,
`ifdef SLOW_PERIPH_EXT_WAIT_EN
  input  logic              ext_wait_n,
`endif
  input  logic [15:0]       ext_din
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD, ST_TURN, ST_ACK
  } state_t;

  localparam logic [3:0] C_SETUP  = 4'(SETUP - 1);
  localparam logic [3:0] C_STROBE = 4'(STROBE - 1);
  localparam logic [3:0] C_HOLD   = 4'(HOLD - 1);
  localparam logic [3:0] C_TURN   = 4'(TURN - 1);
  localparam state_t FIRST_PH = (SETUP != 0) ? ST_SETUP : ST_STROBE;

  state_t      r_state;
  state_t      w_nState;
  logic [3:0]  r_cnt;
  logic [3:0]  w_nCnt;
  logic        r_beat;
  logic        w_nBeat;
  logic        r_hasBeat1;
  logic        r_write;
  logic [25:2] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_rbuf;

  logic        w_enter;
  logic        w_endBeat;
  logic        w_moreBeats;
  logic        w_waitN;
  logic        w_strobeDone;
  logic        w_request;
  logic [25:2] w_selAddr;
  logic [3:0]  w_selBe;
  logic [31:0] w_selData;
  logic        w_selWr;
  logic [1:0]  w_beHalf;
  logic [15:0] w_dataHalf;
  logic        w_active;
  logic        w_inBeat;
  logic [25:0] w_hw;
  logic        w_unused;

`ifdef SLOW_PERIPH_EXT_WAIT_EN
  logic [1:0] r_waitSync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_waitSync <= 2'b11;
    else       r_waitSync <= {r_waitSync[0], ext_wait_n};
  end

  assign w_waitN = r_waitSync[1];
`else
  assign w_waitN = 1'b1;
`endif

  assign w_request     = s_read | s_write;
  assign w_moreBeats   = !r_beat && r_hasBeat1;
  assign w_strobeDone  = (r_cnt == 4'd0) && w_waitN;
  assign s_waitrequest = (r_state == ST_IDLE) ? w_request : (r_state != ST_ACK);

  always_comb begin
    w_nState  = r_state;
    w_nBeat   = r_beat;
    w_enter   = 1'b0;
    w_endBeat = 1'b0;
    w_nCnt    = (r_cnt != 4'd0) ? r_cnt - 4'd1 : 4'd0;
    case (r_state)
      ST_IDLE: begin
        if (w_request) begin
          w_enter = 1'b1;
          if (s_byteenable[1:0] != 2'b00) begin
            w_nBeat  = 1'b0;
            w_nState = FIRST_PH;
          end else if (s_byteenable[3:2] != 2'b00) begin
            w_nBeat  = 1'b1;
            w_nState = FIRST_PH;
          end else begin
            w_nState = ST_ACK;
          end
        end
      end
      ST_SETUP: begin
        if (r_cnt == 4'd0) begin
          w_enter  = 1'b1;
          w_nState = ST_STROBE;
        end
      end
      ST_STROBE: begin
        if (w_strobeDone) begin
          w_enter = 1'b1;
          if (HOLD != 0)      w_nState  = ST_HOLD;
          else if (TURN != 0) w_nState  = ST_TURN;
          else                w_endBeat = 1'b1;
        end
      end
      ST_HOLD: begin
        if (r_cnt == 4'd0) begin
          w_enter = 1'b1;
          if (TURN != 0) w_nState  = ST_TURN;
          else           w_endBeat = 1'b1;
        end
      end
      ST_TURN: begin
        if (r_cnt == 4'd0) begin
          w_enter   = 1'b1;
          w_endBeat = 1'b1;
        end
      end
      ST_ACK:  w_nState = ST_IDLE;
      default: w_nState = ST_IDLE;
    endcase
    // Only the low beat can be followed by another, so the next beat is always beat 1.
    if (w_endBeat) begin
      w_nBeat  = 1'b1;
      w_nState = w_moreBeats ? FIRST_PH : ST_ACK;
    end
    if (w_enter) begin
      case (w_nState)
        ST_SETUP:  w_nCnt = C_SETUP;
        ST_STROBE: w_nCnt = C_STROBE;
        ST_HOLD:   w_nCnt = C_HOLD;
        ST_TURN:   w_nCnt = C_TURN;
        default:   w_nCnt = 4'd0;
      endcase
    end
  end

  // Bus outputs are computed from the next state so they change on the edge that enters it.
  always_comb begin
    w_selAddr  = (r_state == ST_IDLE) ? s_address[25:2] : r_addr;
    w_selBe    = (r_state == ST_IDLE) ? s_byteenable    : r_be;
    w_selData  = (r_state == ST_IDLE) ? s_writedata     : r_wdata;
    w_selWr    = (r_state == ST_IDLE) ? s_write         : r_write;
    w_beHalf   = w_nBeat ? w_selBe[3:2]     : w_selBe[1:0];
    w_dataHalf = w_nBeat ? w_selData[31:16] : w_selData[15:0];
    w_active   = (w_nState == ST_SETUP) || (w_nState == ST_STROBE) || (w_nState == ST_HOLD);
    w_inBeat   = w_active || (w_nState == ST_TURN);
  end

  assign w_hw     = {1'b0, w_selAddr, w_nBeat};
  assign w_unused = &{1'b0, s_address[1:0], w_hw[25:ADDR_W]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_beat  <= 1'b0;
    end else begin
      r_state <= w_nState;
      r_cnt   <= w_nCnt;
      r_beat  <= w_nBeat;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr     <= '0;
      r_be       <= 4'd0;
      r_wdata    <= 32'd0;
      r_write    <= 1'b0;
      r_hasBeat1 <= 1'b0;
      r_rbuf     <= 32'd0;
    end else if (r_state == ST_IDLE && w_request) begin
      r_addr     <= s_address[25:2];
      r_be       <= s_byteenable;
      r_wdata    <= s_writedata;
      r_write    <= s_write;
      r_hasBeat1 <= (s_byteenable[3:2] != 2'b00);
      r_rbuf     <= 32'd0;
    end else if (r_state == ST_STROBE && w_strobeDone) begin
      if (r_beat) r_rbuf[31:16] <= ext_din;
      else        r_rbuf[15:0]  <= ext_din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_addr    <= '0;
      ext_cs_n    <= 1'b1;
      ext_oe_n    <= 1'b1;
      ext_we_n    <= 1'b1;
      ext_be_n    <= 2'b11;
      ext_dout    <= 16'd0;
      ext_dout_en <= 1'b0;
    end else begin
      if (w_inBeat) ext_addr <= w_hw[ADDR_W-1:0];
      ext_cs_n    <= !w_active;
      ext_oe_n    <= !((w_nState == ST_STROBE) && !w_selWr);
      ext_we_n    <= !((w_nState == ST_STROBE) && w_selWr);
      ext_be_n    <= w_active ? ~w_beHalf : 2'b11;
      ext_dout_en <= w_active && w_selWr;
      ext_dout    <= (w_active && w_selWr) ? w_dataHalf : 16'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_readdata      <= 32'd0;
      s_readdatavalid <= 1'b0;
    end else if (r_state == ST_ACK && !r_write) begin
      s_readdata      <= r_rbuf;
      s_readdatavalid <= 1'b1;
    end else begin
      s_readdatavalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_slow_periph_async_bus_adapter.sv
// Table-driven bench for slow_periph_async_bus_adapter at default timing, with a scoreboard
// for external beats and read returns.
module tb_slow_periph_async_bus_adapter;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [25:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [15:0] din0;
    logic [15:0] din1;
    int          expAck;
    logic [31:0] expRdata;
  } vec_t;

  typedef struct {
    logic [21:0] addr;
    logic [1:0]  ben;
    logic [15:0] dout;
    logic        wr;
    int          start;
  } beat_t;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } rd_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [25:0] s_address = '0;
  logic [3:0]  s_byteenable = '0;
  logic        s_read = 1'b0;
  logic        s_write = 1'b0;
  logic [31:0] s_writedata = '0;
  logic        s_waitrequest;
  logic [31:0] s_readdata;
  logic        s_readdatavalid;
  logic [21:0] ext_addr;
  logic        ext_cs_n, ext_oe_n, ext_we_n;
  logic [1:0]  ext_be_n;
  logic [15:0] ext_dout;
  logic        ext_dout_en;
  logic [15:0] ext_din;
  logic [15:0] curDin0 = '0;
  logic [15:0] curDin1 = '0;
`ifdef SLOW_PERIPH_EXT_WAIT_EN
  logic        ext_wait_n = 1'b1;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  beat_t beatQ[$];
  rd_t   rdQ[$];
  vec_t  vecs[9];

  slow_periph_async_bus_adapter dut (
    .clk(clk), .reset(reset),
    .s_address(s_address), .s_byteenable(s_byteenable),
    .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid),
    .ext_addr(ext_addr), .ext_cs_n(ext_cs_n), .ext_oe_n(ext_oe_n),
    .ext_we_n(ext_we_n), .ext_be_n(ext_be_n), .ext_dout(ext_dout),
    .ext_dout_en(ext_dout_en),
`ifdef SLOW_PERIPH_EXT_WAIT_EN
    .ext_wait_n(ext_wait_n),
`endif
    .ext_din(ext_din)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Peripheral model: drives the addressed half while output enable is low.
  assign ext_din = ext_oe_n ? 16'hFFFF : (ext_addr[0] ? curDin1 : curDin0);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pushExpect(input vec_t v, input int t0);
    logic [25:0] hw;
    logic [1:0]  half;
    int          start;
    start = t0 + 3;
    for (int b = 0; b < 2; b++) begin
      half = (b == 1) ? v.be[3:2] : v.be[1:0];
      if (half != 2'b00) begin
        hw = {v.addr[25:2], 1'(b)};
        beatQ.push_back('{hw[21:0], ~half,
                          v.wr ? ((b == 1) ? v.wdata[31:16] : v.wdata[15:0]) : 16'h0000,
                          v.wr, start});
        start = start + 8;
      end
    end
    if (v.rd && !v.wr) rdQ.push_back('{v.expRdata, t0 + v.expAck + 1});
  endtask

  task automatic applyStimulus(input vec_t v);
    int t0;
    int n;
    @(posedge clk); #1;
    s_read = v.rd; s_write = v.wr; s_address = v.addr;
    s_byteenable = v.be; s_writedata = v.wdata;
    curDin0 = v.din0; curDin1 = v.din1;
    t0 = cyc;
    pushExpect(v, t0);
    @(negedge clk);
    checkOutput("waitreq_idle_req", s_waitrequest, 1'b1);
    n = 0;
    while (s_waitrequest && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (s_waitrequest) begin
      checks++;
      errors++;
      $display("[TB] FAIL ack_timeout: got no ACK after %0d cycles, expected ACK at %0d", n, v.expAck);
      s_read = 1'b0; s_write = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
    end else begin
      checkOutput("ack_cycle", cyc - t0, v.expAck);
      checkOutput("cs_idle_at_ack", ext_cs_n, 1'b1);
    end
  endtask

  // Monitor: pops expected beats at strobe entry and read returns at readdatavalid.
  logic        prevStb = 1'b0;
  int          stbLen = 0;
  int          csRun = 0;
  logic [31:0] heldRdata = '0;
  always @(negedge clk) begin
    beat_t eb;
    rd_t   er;
    logic  stb;
    if (reset) begin
      beatQ.delete();
      rdQ.delete();
      heldRdata = '0;
      prevStb = 1'b0;
      stbLen = 0;
      csRun = 0;
    end else begin
      stb = !ext_oe_n || !ext_we_n;
      checkOutput("oe_we_exclusive", {31'd0, !ext_oe_n && !ext_we_n}, 32'd0);
      if (!ext_cs_n) csRun++;
      else begin
        if (csRun != 0) checkOutput("cs_len", csRun, 7);
        csRun = 0;
      end
      if (stb && !prevStb) begin
        if (beatQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat: got strobe at addr 0x%0h, expected none", ext_addr);
        end else begin
          eb = beatQ.pop_front();
          checkOutput("beat_addr", ext_addr, eb.addr);
          checkOutput("beat_be_n", ext_be_n, eb.ben);
          checkOutput("beat_dout", ext_dout, eb.dout);
          checkOutput("beat_dout_en", ext_dout_en, eb.wr);
          checkOutput("beat_we_n", ext_we_n, !eb.wr);
          checkOutput("beat_start", cyc, eb.start);
          checkOutput("beat_setup", csRun, 3);
        end
        stbLen = 1;
      end else if (stb) begin
        stbLen++;
      end else if (prevStb) begin
        checkOutput("strobe_len", stbLen, 4);
      end
      prevStb = stb;
      if (s_readdatavalid) begin
        if (rdQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_rdvalid: got data 0x%0h, expected no readdatavalid", s_readdata);
        end else begin
          er = rdQ.pop_front();
          checkOutput("readdata", s_readdata, er.data);
          checkOutput("rdvalid_cycle", cyc, er.cyc);
          heldRdata = er.data;
        end
      end else begin
        checkOutput("rdata_hold", s_readdata, heldRdata);
      end
    end
  end

  initial begin
    vec_t rv;
    int   t0;
    vecs[0] = '{1'b1, 1'b0, 26'h0000010, 4'hF, 32'h0,        16'h1234, 16'hABCD, 17, 32'hABCD1234};
    vecs[1] = '{1'b0, 1'b1, 26'h0000010, 4'hC, 32'hDEADBEEF, 16'h0,    16'h0,     9, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 26'h0000100, 4'h0, 32'h0,        16'h1111, 16'h2222,  1, 32'h00000000};
    vecs[3] = '{1'b0, 1'b1, 26'h0000020, 4'hF, 32'h11223344, 16'h0,    16'h0,    17, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 26'h0000020, 4'h3, 32'h0,        16'h5678, 16'h9999,  9, 32'h00005678};
    vecs[5] = '{1'b1, 1'b0, 26'h3FFFFFC, 4'h8, 32'h0,        16'h7777, 16'hCAFE,  9, 32'hCAFE0000};
    vecs[6] = '{1'b0, 1'b1, 26'h0000044, 4'h1, 32'hAAAA55CC, 16'h0,    16'h0,     9, 32'h0};
    vecs[7] = '{1'b0, 1'b1, 26'h0000080, 4'h0, 32'h12345678, 16'h0,    16'h0,     1, 32'h0};
    vecs[8] = '{1'b1, 1'b1, 26'h0000008, 4'h3, 32'h0BADF00D, 16'h4444, 16'h4444,  9, 32'h0};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_waitrequest", s_waitrequest, 1'b0);
    checkOutput("rst_readdata", s_readdata, 32'h0);
    checkOutput("rst_rdvalid", s_readdatavalid, 1'b0);
    checkOutput("rst_cs_n", ext_cs_n, 1'b1);
    checkOutput("rst_oe_n", ext_oe_n, 1'b1);
    checkOutput("rst_we_n", ext_we_n, 1'b1);
    checkOutput("rst_be_n", ext_be_n, 2'b11);
    checkOutput("rst_dout_en", ext_dout_en, 1'b0);
    checkOutput("rst_addr", ext_addr, 22'h0);
    checkOutput("rst_dout", ext_dout, 16'h0);

    // Vectors run back to back: each new request appears in the IDLE cycle after the previous ACK.
    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);
    @(posedge clk); #1;
    s_read = 1'b0; s_write = 1'b0;
    repeat (3) @(posedge clk);

    // Reset in cycle 5 of a read: outputs drop at once and the read never returns.
    rv = '{1'b1, 1'b0, 26'h0000040, 4'hF, 32'h0, 16'h0F0F, 16'hF0F0, 17, 32'hF0F00F0F};
    @(posedge clk); #1;
    s_read = 1'b1; s_address = rv.addr; s_byteenable = rv.be;
    curDin0 = rv.din0; curDin1 = rv.din1;
    t0 = cyc;
    pushExpect(rv, t0);
    while (cyc < t0 + 5) @(posedge clk);
    #1;
    reset = 1'b1;
    s_read = 1'b0;
    #1;
    checkOutput("midrst_cs_n", ext_cs_n, 1'b1);
    checkOutput("midrst_oe_n", ext_oe_n, 1'b1);
    checkOutput("midrst_dout_en", ext_dout_en, 1'b0);
    checkOutput("midrst_waitrequest", s_waitrequest, 1'b0);
    checkOutput("midrst_rdvalid", s_readdatavalid, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    applyStimulus(rv);
    @(posedge clk); #1;
    s_read = 1'b0; s_write = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("rdq_drained", rdQ.size(), 0);
    checkOutput("beatq_drained", beatQ.size(), 0);
    checkOutput("idle_waitrequest", s_waitrequest, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
